// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : RV32I data-memory target with valid/ready request and
//                response channels and a programmable wait-state delay.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] c_wload = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic [2:0]  r_func3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_cnt;

   logic [31:0] mem [DEPTH];

   logic        w_we;
   logic [2:0]  w_func3;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_legal;
   logic        w_align;
   logic        w_ok;
   logic [c_aw-1:0] w_idx;
   logic [31:0] w_word;
   logic [31:0] w_shift;
   logic [31:0] w_ldata;
   logic [3:0]  w_be;
   logic [31:0] w_wlanes;
   logic        w_access;
   logic        w_commit;

   // In IDLE the live request drives the access path so WAIT_CYCLES==0 can
   // complete on the accepting edge; otherwise the captured copy is used.
   always_comb begin
      w_we    = r_we;
      w_func3 = r_func3;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      if (r_state == S_IDLE) begin
         w_we    = req_we;
         w_func3 = req_func3;
         w_addr  = req_addr;
         w_wdata = req_wdata;
      end
   end

   always_comb begin
      w_legal = 1'b0;
      w_align = 1'b0;
      case (w_func3)
         3'b000: begin w_legal = 1'b1;  w_align = 1'b1;                 end
         3'b001: begin w_legal = 1'b1;  w_align = ~w_addr[0];           end
         3'b010: begin w_legal = 1'b1;  w_align = (w_addr[1:0] == 2'b00); end
         3'b100: begin w_legal = ~w_we; w_align = 1'b1;                 end
         3'b101: begin w_legal = ~w_we; w_align = ~w_addr[0];           end
         default: begin w_legal = 1'b0; w_align = 1'b0;                 end
      endcase
      w_ok = w_legal & w_align & (w_addr[31:2] < 30'(DEPTH));
   end

   assign w_idx   = w_addr[c_aw+1:2];
   assign w_word  = mem[w_idx];
   assign w_shift = w_word >> {w_addr[1:0], 3'b000};

   always_comb begin
      case (w_func3)
         3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ldata = {24'd0, w_shift[7:0]};
         3'b101:  w_ldata = {16'd0, w_shift[15:0]};
         default: w_ldata = w_word;
      endcase
   end

   always_comb begin
      case (w_func3[1:0])
         2'b00: begin
            w_be     = 4'b0001 << w_addr[1:0];
            w_wlanes = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = 4'b0011 << w_addr[1:0];
            w_wlanes = {2{w_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wlanes = w_wdata;
         end
      endcase
   end

   // Gating with reset keeps a store from landing on a reset edge.
   assign w_access = reset &&
                     (((r_state == S_IDLE) && req_valid && w_ok && (WAIT_CYCLES == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0)));
   assign w_commit = w_access && w_we;

   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         r_cnt     <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  r_func3   <= req_func3;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  req_ready <= 1'b0;
                  if (!w_ok) begin
                     r_state   <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'd0;
                  end else if (WAIT_CYCLES == 0) begin
                     r_state   <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= w_we ? 32'd0 : w_ldata;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= c_wload;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state   <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= r_we ? 32'd0 : w_ldata;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state   <= S_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Randomized self-checking bench for dmem_responder against a
//                byte-level memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int WAIT  = 2;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [2:0]  req_func3 = 3'd0;
   logic [31:0] req_addr  = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_ready = 1'b1;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_func3 (req_func3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mdl [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: the memory as bytes; access size, alignment and range from the ISA rules.
   function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
      int          sz;
      bit          legal;
      int          sv;
      logic [31:0] v;
      legal = 1'b1;
      case (f3)
         3'd0:    sz = 1;
         3'd1:    sz = 2;
         3'd2:    sz = 4;
         3'd4:    begin sz = 1; legal = !we; end
         3'd5:    begin sz = 2; legal = !we; end
         default: begin sz = 1; legal = 1'b0; end
      endcase
      err = !legal || ((a % sz) != 0) || (longint'(a) >= longint'(DEPTH) * 4);
      rd  = 32'd0;
      if (err) return;
      if (we) begin
         for (int i = 0; i < sz; i++)
            mdl[a / 4][8 * (int'(a % 4) + i) +: 8] = wd[8 * i +: 8];
      end else begin
         v = mdl[a / 4] >> (8 * (a % 4));
         case (f3)
            3'd0:    begin sv = $signed(v[7:0]);  rd = sv; end
            3'd1:    begin sv = $signed(v[15:0]); rd = sv; end
            3'd4:    rd = {24'd0, v[7:0]};
            3'd5:    rd = {16'd0, v[15:0]};
            default: rd = v;
         endcase
      end
   endfunction

   task automatic txn(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, input bit keepv);
      logic [31:0] erd;
      bit          eerr;
      int          cnt;
      cnt = 0;
      while (!req_ready && cnt < 50) begin step(); cnt++; end
      check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
      model(we, f3, a, wd, erd, eerr);
      req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
      rsp_ready = (hold == 0);
      step();
      // Inputs are don't-care once accepted; scramble them.
      req_valid = keepv; req_we = 1'($urandom); req_func3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      cnt = 0;
      while (!rsp_valid && cnt < 50) begin step(); cnt++; end
      check({tag, "_lat"}, 32'(cnt), eerr ? 32'd0 : 32'(WAIT));
      check({tag, "_rdata"}, rsp_rdata, erd);
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, eerr});
      for (int i = 0; i < hold; i++) begin
         step();
         check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
         check({tag, "_hold_rdata"}, rsp_rdata, erd);
         check({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, eerr});
         check({tag, "_hold_rdy"}, {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      step();
      check({tag, "_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_hs_rdy"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      step();
      check({tag, "_no_second"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_still_idle"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int          cnt;
      int          w;
      logic [31:0] a;
      reset = 1'b0;
      step();
      step();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", {31'd0, rsp_err}, 32'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 16; i++) txn("pre", 1'b1, 3'd2, 32'(i * 4), $urandom, 0, 1'b0);
      txn("pre_hi0", 1'b1, 3'd2, 32'(DEPTH * 4 - 8), $urandom, 0, 1'b0);
      txn("pre_hi1", 1'b1, 3'd2, 32'(DEPTH * 4 - 4), $urandom, 0, 1'b0);

      txn("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0);
      txn("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
      txn("sb11", 1'b1, 3'd0, 32'h11, 32'h80, 0, 1'b0);
      txn("lb11", 1'b0, 3'd0, 32'h11, 32'h0, 0, 1'b0);
      txn("lbu11", 1'b0, 3'd4, 32'h11, 32'h0, 0, 1'b0);
      txn("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
      txn("sh12", 1'b1, 3'd1, 32'h12, 32'h1234, 0, 1'b0);
      txn("lh12", 1'b0, 3'd1, 32'h12, 32'h0, 0, 1'b0);
      txn("lw10c", 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
      check("lw10c_const", mdl[4], 32'h123480EF);
      txn("lw13", 1'b0, 3'd2, 32'h13, 32'h0, 0, 1'b0);
      txn("sh15", 1'b1, 3'd1, 32'h15, 32'hFFFF, 0, 1'b0);
      txn("lw14", 1'b0, 3'd2, 32'h14, 32'h0, 0, 1'b0);
      txn("lw_oor", 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 0, 1'b0);
      txn("lw_last", 1'b0, 3'd2, 32'(DEPTH * 4 - 4), 32'h0, 0, 1'b0);
      txn("ld_f011", 1'b0, 3'd3, 32'h10, 32'h0, 0, 1'b0);
      txn("st_f100", 1'b1, 3'd4, 32'h10, 32'h55, 0, 1'b0);
      txn("hold5", 1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b1);

      // Reset in the first WAIT cycle drops the store.
      req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      step();
      req_valid = 1'b0;
      check("w6_busy", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      step();
      step();
      check("w6_req_ready", {31'd0, req_ready}, 32'd1);
      check("w6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("w6_rdata", rsp_rdata, 32'd0);
      check("w6_err", {31'd0, rsp_err}, 32'd0);
      reset = 1'b1;
      step();
      txn("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0);

      // Reset while a response is pending drops it.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd2; req_addr = 32'h0;
      step();
      req_valid = 1'b0;
      cnt = 0;
      while (!rsp_valid && cnt < 50) begin step(); cnt++; end
      check("r_resp_seen", {31'd0, rsp_valid}, 32'd1);
      reset = 1'b0;
      step();
      check("r_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("r_req_ready", {31'd0, req_ready}, 32'd1);
      check("r_rdata", rsp_rdata, 32'd0);
      reset = 1'b1;
      rsp_ready = 1'b1;
      step();
      check("r_no_resp", {31'd0, rsp_valid}, 32'd0);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4 + $urandom_range(0, 15)) : ($urandom | 32'h8000_0000);
         end else begin
            w = ($urandom_range(0, 7) == 0) ? DEPTH - 2 + $urandom_range(0, 1) : $urandom_range(0, 15);
            a = 32'(w * 4 + $urandom_range(0, 3));
         end
         txn("rnd", 1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
